// File: rtl/gppcu_lmem_host_ctrl.sv
// gppcu_lmem_host_ctrl: host single-beat access to per-thread local memories via their shared external port
module gppcu_lmem_host_ctrl #(
  parameter int NUM_THREAD = 8,
  parameter int TBW        = 3,
  parameter int ABW        = 11,
  parameter int DBW        = 32
) (
  input  logic                      iACLK,
  input  logic                      iARESETn,
  input  logic [TBW+ABW-1:0]        iHOST_ADDR,
  input  logic                      iHOST_RD,
  input  logic                      iHOST_WR,
  input  logic                      iHOST_BCAST,
  input  logic [DBW-1:0]            iHOST_WDATA,
  output logic                      oHOST_WAITREQ,
  output logic [DBW-1:0]            oHOST_RDATA,
  output logic                      oHOST_RVALID,
  input  logic                      iLOCK,
  output logic [NUM_THREAD-1:0]     oLMEMSEL,
  output logic                      oLMEMWREN,
  output logic [ABW-1:0]            oLMEMADDR,
  output logic [DBW-1:0]            oLMEMWDATA,
  input  logic [NUM_THREAD*DBW-1:0] iLMEMRDATA,
  output logic [7:0]                oERRCNT
);
  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_WAIT} stateT;
  localparam logic [TBW:0] NT = (TBW+1)'(NUM_THREAD);
  stateT state;
  logic [TBW-1:0] thrIn, thrQ;
  logic accept, wrBcast, outRange;
  logic [NUM_THREAD-1:0] selIn;
  logic [DBW-1:0] rdWord;
  assign thrIn = iHOST_ADDR[TBW+ABW-1:ABW];
  assign accept = state == IDLE && !iLOCK && (iHOST_RD || iHOST_WR);
  assign wrBcast = iHOST_WR & iHOST_BCAST;
  assign outRange = {1'b0, thrIn} >= NT;
  assign oHOST_WAITREQ = state != IDLE || iLOCK;
  // an out-of-range index matches no thread, so it selects nothing and reads back zero
  always_comb begin
    selIn = '0;
    rdWord = '0;
    for (int i = 0; i < NUM_THREAD; i++) begin
      selIn[i] = wrBcast | (thrIn == TBW'(i));
      if (thrQ == TBW'(i)) rdWord = iLMEMRDATA[i*DBW +: DBW];
    end
  end
  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) begin
      state <= IDLE;
      thrQ <= '0;
      oLMEMSEL <= '0;
      oLMEMWREN <= 1'b0;
      oLMEMADDR <= '0;
      oLMEMWDATA <= '0;
      oHOST_RDATA <= '0;
      oHOST_RVALID <= 1'b0;
      oERRCNT <= '0;
    end else begin
      oLMEMSEL <= '0;
      oLMEMWREN <= 1'b0;
      oHOST_RVALID <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= iHOST_WR ? WR : RD_ADDR;
          thrQ <= thrIn;
          oLMEMSEL <= selIn;
          oLMEMWREN <= iHOST_WR;
          oLMEMADDR <= iHOST_ADDR[ABW-1:0];
          if (iHOST_WR) oLMEMWDATA <= iHOST_WDATA;
          if (outRange && !wrBcast && oERRCNT != 8'hFF) oERRCNT <= oERRCNT + 8'd1;
        end
        WR: state <= IDLE;
        RD_ADDR: state <= RD_WAIT;
        default: begin
          state <= IDLE;
          oHOST_RDATA <= rdWord;
          oHOST_RVALID <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gppcu_lmem_host_ctrl.sv
// tb_gppcu_lmem_host_ctrl: directed and random host traffic against a transaction-level memory model
module tb_gppcu_lmem_host_ctrl;
  localparam int NT = 6, TBW = 3, ABW = 11, DBW = 32;
  logic clk = 1'b0;
  logic rstN;
  logic [TBW+ABW-1:0] hostAddr;
  logic hostRd, hostWr, hostBcast, lock;
  logic [DBW-1:0] hostWdata, rdata, lmWdata;
  logic waitReq, rvalid, wren;
  logic [NT-1:0] sel;
  logic [ABW-1:0] lmAddr;
  logic [NT*DBW-1:0] lmRdata;
  logic [7:0] errCnt;
  int nChecks = 0, nErrors = 0, refErr = 0;
  logic [DBW-1:0] ram [NT][2048] = '{default: '0};
  logic [DBW-1:0] refMem [NT][2048] = '{default: '0};
  logic [DBW-1:0] ramQ [NT];

  always #5 clk = ~clk;

  gppcu_lmem_host_ctrl #(.NUM_THREAD(NT), .TBW(TBW), .ABW(ABW), .DBW(DBW)) dut (
    .iACLK(clk), .iARESETn(rstN), .iHOST_ADDR(hostAddr), .iHOST_RD(hostRd), .iHOST_WR(hostWr),
    .iHOST_BCAST(hostBcast), .iHOST_WDATA(hostWdata), .oHOST_WAITREQ(waitReq), .oHOST_RDATA(rdata),
    .oHOST_RVALID(rvalid), .iLOCK(lock), .oLMEMSEL(sel), .oLMEMWREN(wren), .oLMEMADDR(lmAddr),
    .oLMEMWDATA(lmWdata), .iLMEMRDATA(lmRdata), .oERRCNT(errCnt)
  );

  // thread local memories: registered read, selected threads only
  always @(posedge clk)
    for (int i = 0; i < NT; i++)
      if (sel[i]) begin
        ramQ[i] <= ram[i][lmAddr];
        if (wren) ram[i][lmAddr] <= lmWdata;
      end
  for (genvar g = 0; g < NT; g++) begin : gRd
    assign lmRdata[g*DBW +: DBW] = ramQ[g];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitAccept(input string tag);
    int n = 0;
    while (waitReq && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (waitReq) chk(tag, waitReq, 0);
  endtask

  function automatic logic [NT-1:0] expSel(input int thr, input logic bc);
    logic [NT-1:0] e = '0;
    if (bc) e = '1;
    else if (thr < NT) e[thr] = 1'b1;
    return e;
  endfunction

  function automatic void bumpErr();
    if (refErr < 255) refErr++;
  endfunction

  task automatic doWrite(input int thr, input int a, input logic [31:0] d, input logic bc);
    @(negedge clk);
    hostAddr = {TBW'(thr), ABW'(a)};
    hostWdata = d;
    hostBcast = bc;
    hostWr = 1'b1;
    #1 waitAccept("wr_accept");
    @(negedge clk);
    hostWr = 1'b0;
    hostBcast = 1'b0;
    chk("wr_wren", wren, 1);
    chk("wr_sel", sel, expSel(thr, bc));
    chk("wr_addr", lmAddr, a);
    chk("wr_data", lmWdata, d);
    chk("wr_busy", waitReq, 1);
    if (bc) for (int i = 0; i < NT; i++) refMem[i][a] = d;
    else if (thr < NT) refMem[thr][a] = d;
    else bumpErr();
    @(negedge clk);
    chk("wr_done", {wren, sel}, 0);
    chk("wr_free", waitReq, lock);
    chk("wr_errcnt", errCnt, refErr);
  endtask

  task automatic doRead(input int thr, input int a, input logic bc);
    @(negedge clk);
    hostAddr = {TBW'(thr), ABW'(a)};
    hostBcast = bc;
    hostRd = 1'b1;
    #1 waitAccept("rd_accept");
    @(negedge clk);
    hostRd = 1'b0;
    hostBcast = 1'b0;
    chk("rd_sel", sel, expSel(thr, 1'b0));
    chk("rd_wren", wren, 0);
    chk("rd_addr", lmAddr, a);
    chk("rd_early1", rvalid, 0);
    if (thr >= NT) bumpErr();
    @(negedge clk);
    chk("rd_early2", rvalid, 0);
    @(negedge clk);
    chk("rd_rvalid", rvalid, 1);
    chk("rd_data", rdata, thr < NT ? refMem[thr][a] : 32'h0);
    chk("rd_errcnt", errCnt, refErr);
    @(negedge clk);
    chk("rd_pulse", rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rstN = 1'b0;
    hostAddr = '0; hostRd = 0; hostWr = 0; hostBcast = 0; hostWdata = '0; lock = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl", {sel, wren, lmAddr}, 0);
    chk("rst_wdata", lmWdata, 0);
    chk("rst_rdata", {rdata, rvalid}, 0);
    chk("rst_errcnt", errCnt, 0);
    chk("rst_waitreq", waitReq, 0);
    lock = 1'b1;
    #1 chk("rst_waitreq_lock", waitReq, 1);
    lock = 1'b0;
    @(negedge clk) rstN = 1'b1;

    doWrite(3, 'h010, 32'hA5A5_0001, 0);
    doRead(3, 'h010, 0);
    doWrite(7, 'h010, 32'hDEAD_BEEF, 0);
    chk("oor_wr_cnt", errCnt, 1);
    doRead(6, 'h010, 0);
    chk("oor_rd_cnt", errCnt, 2);

    doWrite(7, 'h7FF, 32'h1234_5678, 1);
    for (int t = 0; t < NT; t++) doRead(t, 'h7FF, t[0]);

    // lock holds off a pending read, then releases it
    @(negedge clk);
    lock = 1'b1; hostRd = 1'b1; hostAddr = {3'd3, 11'h010};
    repeat (3) begin
      @(negedge clk);
      chk("lock_wait", waitReq, 1);
      chk("lock_idle", {sel, rvalid}, 0);
    end
    lock = 1'b0;
    #1 chk("lock_release", waitReq, 0);
    @(negedge clk) hostRd = 1'b0;
    chk("lock_sel", sel, 6'b001000);
    repeat (2) @(negedge clk);
    chk("lock_rvalid", rvalid, 1);
    chk("lock_rdata", rdata, 32'hA5A5_0001);
    @(negedge clk);
    hostRd = 1'b1; hostAddr = {3'd3, 11'h7FF};
    @(negedge clk);
    hostRd = 1'b0; lock = 1'b1;
    repeat (2) @(negedge clk);
    chk("midlock_rvalid", rvalid, 1);
    chk("midlock_rdata", rdata, 32'h1234_5678);
    chk("midlock_wait", waitReq, 1);
    lock = 1'b0;

    // RD and WR together: only the write happens
    @(negedge clk);
    hostRd = 1'b1; hostWr = 1'b1; hostAddr = {3'd2, 11'h020}; hostWdata = 32'hCAFE_0002;
    @(negedge clk);
    hostRd = 1'b0; hostWr = 1'b0;
    chk("both_wren", wren, 1);
    chk("both_sel", sel, 6'b000100);
    refMem[2]['h020] = 32'hCAFE_0002;
    repeat (3) begin
      @(negedge clk);
      chk("both_no_rvalid", rvalid, 0);
    end
    doRead(2, 'h020, 0);

    // streaming: held WR accepted every 2nd cycle, held RD every 3rd
    @(negedge clk);
    hostWr = 1'b1; hostAddr = {3'd4, 11'h030}; hostWdata = 32'h0BAD_F00D;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cnt += int'(wren);
      if (k == 12) hostWr = 1'b0;
    end
    chk("stream_wr", cnt, 6);
    refMem[4]['h030] = 32'h0BAD_F00D;
    @(negedge clk) hostRd = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (rvalid) begin
        cnt++;
        chk("stream_rdata", rdata, 32'h0BAD_F00D);
      end
      if (k == 12) hostRd = 1'b0;
    end
    chk("stream_rd", cnt, 4);

    // reset during RD_WAIT kills the read
    @(negedge clk);
    hostRd = 1'b1; hostAddr = {3'd3, 11'h010};
    @(negedge clk) hostRd = 1'b0;
    @(negedge clk) rstN = 1'b0;
    #1;
    chk("mrst_ctl", {sel, wren, lmAddr}, 0);
    chk("mrst_rd", {rdata, rvalid}, 0);
    chk("mrst_misc", {lmWdata, errCnt}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("mrst_no_rvalid", rvalid, 0);
    end
    rstN = 1'b1;
    refErr = 0;
    doRead(3, 'h010, 0);

    for (int n = 0; n < 150; n++) begin
      int thr = $urandom_range(0, 7);
      int a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) doWrite(thr, a, $urandom, $urandom_range(0, 3) == 0);
      else doRead(thr, a, $urandom_range(0, 1) == 1);
    end

    // 300 streamed bad writes saturate the error counter
    @(negedge clk);
    hostWr = 1'b1; hostAddr = {3'd7, 11'h000};
    repeat (600) @(negedge clk);
    hostWr = 1'b0;
    refErr = 255;
    @(negedge clk);
    chk("errcnt_sat", errCnt, 255);
    doRead(6, 'h001, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/gppcu_lmem_host_ctrl.md
# gppcu_lmem_host_ctrl

Host-side access controller for the per-thread local memories of the GPPCU thread array. It accepts single-beat host read/write requests on a waitrequest-style bus and decodes the thread index from the upper address bits. It drives the shared external port (SEL/WREN/ADDR/WDATA) of all thread local memories and returns the selected thread's read data. It sits between the host bus bridge and the array of GPPCU threads, and blocks new host accesses while a kernel holds the lock.

## Interface
- NUM_THREAD, 8, number of thread local memories attached (1..2^TBW)
- TBW, 3, thread-index bits in host address
- ABW, 11, local-memory word address bits (2048 words)
- DBW, 32, data width
- iACLK  in  1  clock; also clocks the local-memory external port
- iARESETn  in  1  reset, asynchronous, active-low
- iHOST_ADDR  in  TBW+ABW  [TBW+ABW-1:ABW] thread index, [ABW-1:0] word address
- iHOST_RD  in  1  read request, held until accepted
- iHOST_WR  in  1  write request, held until accepted
- iHOST_BCAST  in  1  with iHOST_WR: write the word to all threads
- iHOST_WDATA  in  DBW  write data
- oHOST_WAITREQ  out  1  request not accepted this cycle
- oHOST_RDATA  out  DBW  read data, valid when oHOST_RVALID
- oHOST_RVALID  out  1  one-cycle read-data strobe
- iLOCK  in  1  kernel running; blocks new accepts
- oLMEMSEL  out  NUM_THREAD  per-thread select, one-hot or all-ones
- oLMEMWREN  out  1  write enable to external port
- oLMEMADDR  out  ABW  word address
- oLMEMWDATA  out  DBW  write data
- iLMEMRDATA  in  NUM_THREAD*DBW  flattened read data; thread i at [i*DBW+:DBW]; 1-cycle registered RAM read
- oERRCNT  out  8  saturating count of out-of-range accesses

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_WAIT.
- oHOST_WAITREQ is combinational: 1 when state≠IDLE or iLOCK=1; otherwise 0.
- Accept: IDLE & ~iLOCK & (iHOST_RD | iHOST_WR). On accept, latch address, data, kind and bcast.
- RD and WR both high: WR wins, and the read is discarded (it is treated as accepted).
- Write: IDLE→WR. In WR, drive oLMEMWREN=1, ADDR/WDATA latched, SEL = one-hot(thread) or all-ones if bcast. Then WR→IDLE.
- Read: IDLE→RD_ADDR (ADDR/SEL driven, WREN=0) →RD_WAIT. At the end of RD_WAIT, capture iLMEMRDATA slice of the latched thread into oHOST_RDATA and set oHOST_RVALID=1 for the next cycle. RD_WAIT→IDLE.
- iHOST_BCAST on a read is ignored (normal read).
- Out-of-range thread index (≥NUM_THREAD) on a non-bcast access:
  - SEL all-zero; the FSM sequence is unchanged.
  - A read returns 0 with RVALID.
  - oERRCNT increments and saturates at 255.
- oLMEMSEL/oLMEMWREN are 0 in IDLE. ADDR/WDATA hold their last values.
- iLOCK asserted mid-operation: the in-flight access completes normally; only new accepts are blocked.
- oHOST_RDATA holds its value until the next read capture.

## Timing
- All outputs registered except oHOST_WAITREQ.
- Reset values: FSM=IDLE; oLMEMSEL=0, oLMEMWREN=0, oLMEMADDR=0, oLMEMWDATA=0, oHOST_RDATA=0, oHOST_RVALID=0, oERRCNT=0. oHOST_WAITREQ follows iLOCK.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - An in-flight read produces no RVALID.
  - An in-flight write may be lost.
- Write accepted in cycle T: WREN/SEL high in T+1 only. The next accept is possible in T+2 (throughput 1 per 2 cycles).
- Read accepted in cycle T: RD_ADDR in T+1, RD_WAIT in T+2, RVALID high in T+3. The next accept is possible in T+3 (throughput 1 per 3 cycles).
- RVALID is high for exactly one cycle per accepted read, including out-of-range reads.

## Test plan
- Write/read back: write 0xA5A5_0001 to thread 3, addr 0x010 → WREN+SEL=0x08 for one cycle. A read of the same address yields RVALID at T+3 with RDATA=0xA5A5_0001.
- Broadcast: bcast write 0x1234_5678 to addr 0x7FF → SEL=0xFF. Reading addr 0x7FF in every thread 0..7 returns 0x1234_5678.
- Lock: iLOCK=1 with RD held → WAITREQ=1, no SEL activity. Drop iLOCK → accept next cycle and RVALID 3 cycles later. Assert iLOCK during RD_ADDR → RVALID still arrives.
- Conflict/back-to-back: RD=WR=1 → only a write occurs, no RVALID. Streaming writes are accepted every 2nd cycle and streaming reads every 3rd cycle.
- Out-of-range (NUM_THREAD=6): write to thread 7 → SEL=0, oERRCNT=1. A read from thread 6 returns RDATA=0, oERRCNT=2. 300 bad accesses → oERRCNT=255.
- Reset mid-read: deassert iARESETn in RD_WAIT → no RVALID, all outputs 0. After release, a fresh read completes normally.
